// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared AHB/APB bridge codes, defaults and burst helpers
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [31:0] DEFAULT_BASE_ADDR        = 32'h8000_0000;
    localparam int          DEFAULT_REGION_SIZE_LOG2 = 26;

    typedef enum logic [1:0] {
        ERR_IDLE = 2'b00,
        ERR_1    = 2'b01,
        ERR_2    = 2'b10
    } err_state_e;

    // Beats remaining after the NONSEQ beat; zero for SINGLE and INCR.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4, HBURST_INCR4:   return 4'd3;
            HBURST_WRAP8, HBURST_INCR8:   return 4'd7;
            HBURST_WRAP16, HBURST_INCR16: return 4'd15;
            default:                      return 4'd0;
        endcase
    endfunction

    // Address bits allowed to change from beat to beat; all ones for incrementing bursts.
    function automatic logic [31:0] wrap_mask(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4:  return 32'h0000_000F;
            HBURST_WRAP8:  return 32'h0000_001F;
            HBURST_WRAP16: return 32'h0000_003F;
            default:       return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// rtl/ahb_burst_tracker.sv - fixed-length burst beat counter with sticky protocol-violation flag
module ahb_burst_tracker
    import ahb_apb_pkg::*;
(
    input  logic        hclk,
    input  logic        hreset,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hburst,
    input  logic [31:0] haddr,
    input  logic        hreadyin,
    input  logic        abort,
    output logic        burst_err
);

    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] last_addr_q, last_addr_d;
    logic [2:0]  burst_q, burst_d;
    logic        bounded_q, bounded_d;
    logic        open_q, open_d;
    logic        err_q, err_d;
    logic [31:0] mask;
    logic [31:0] exp_addr;

    assign mask     = wrap_mask(burst_q);
    assign exp_addr = (last_addr_q & ~mask) | ((last_addr_q + 32'd4) & mask);

    always_comb begin
        cnt_d       = cnt_q;
        last_addr_d = last_addr_q;
        burst_d     = burst_q;
        bounded_d   = bounded_q;
        open_d      = open_q;
        err_d       = err_q;
        if (hreadyin) begin
            if (abort) begin
                // An errored access ends the burst without counting as a violation.
                cnt_d  = 4'd0;
                open_d = 1'b0;
            end else begin
                case (htrans)
                    HTRANS_NONSEQ: begin
                        if (cnt_q != 4'd0) err_d = 1'b1;
                        cnt_d       = burst_beats(hburst);
                        bounded_d   = (hburst != HBURST_SINGLE) && (hburst != HBURST_INCR);
                        burst_d     = hburst;
                        last_addr_d = haddr;
                        open_d      = 1'b1;
                    end
                    HTRANS_SEQ: begin
                        if (!open_q || (bounded_q && cnt_q == 4'd0) || haddr != exp_addr)
                            err_d = 1'b1;
                        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                        last_addr_d = haddr;
                    end
                    HTRANS_IDLE: begin
                        if (cnt_q != 4'd0) err_d = 1'b1;
                        cnt_d  = 4'd0;
                        open_d = 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            cnt_q       <= 4'd0;
            last_addr_q <= 32'd0;
            burst_q     <= HBURST_SINGLE;
            bounded_q   <= 1'b0;
            open_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            last_addr_q <= last_addr_d;
            burst_q     <= burst_d;
            bounded_q   <= bounded_d;
            open_q      <= open_d;
            err_q       <= err_d;
        end
    end

    assign burst_err = err_q;

endmodule

// File: rtl/ahb_slave_interface.sv
// rtl/ahb_slave_interface.sv - AHB front end of the AHB-to-APB bridge: decode, pipelines, error response
module ahb_slave_interface
    import ahb_apb_pkg::*;
#(
    parameter int          NUM_SLAVES       = 3,
    parameter int          REGION_SIZE_LOG2 = DEFAULT_REGION_SIZE_LOG2,
    parameter logic [31:0] BASE_ADDR        = DEFAULT_BASE_ADDR
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hburst,
    input  logic [2:0]            hsize,
    input  logic                  hwrite,
    input  logic                  hreadyin,
    input  logic [31:0]           haddr,
    input  logic [31:0]           hwdata,
    input  logic [31:0]           prdata,
    input  logic                  hr_readyout,
    output logic                  valid,
    output logic [NUM_SLAVES-1:0] temp_selx,
    output logic [31:0]           haddr1,
    output logic [31:0]           haddr2,
    output logic [31:0]           hwdata1,
    output logic [31:0]           hwdata2,
    output logic                  hwrite_reg,
    output logic                  hwrite_reg1,
    output logic [31:0]           hrdata,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic                  burst_err
);

    logic [31:0] haddr1_q, haddr2_q, hwdata1_q, hwdata2_q;
    logic        hwrite1_q, hwrite2_q;
    err_state_e  state_q;
    logic [1:0]  hresp_q;
    logic        err_ready_q;
    logic [31:0] offset;
    logic [31:0] index;
    logic        active;
    logic        bad_access;

    assign offset = haddr - BASE_ADDR;
    assign index  = offset >> REGION_SIZE_LOG2;

    always_comb begin
        temp_selx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (index == 32'(i)) temp_selx[i] = 1'b1;
        end
    end

    assign active     = hreadyin && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign bad_access = active && ((temp_selx == '0) || (hsize != HSIZE_WORD) || (haddr[1:0] != 2'b00));
    assign valid      = active && !bad_access && (state_q == ERR_IDLE) && !hreset;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            haddr1_q  <= 32'd0;
            haddr2_q  <= 32'd0;
            hwdata1_q <= 32'd0;
            hwdata2_q <= 32'd0;
            hwrite1_q <= 1'b0;
            hwrite2_q <= 1'b0;
        end else if (hreadyin) begin
            haddr1_q  <= haddr;
            haddr2_q  <= haddr1_q;
            hwdata1_q <= hwdata;
            hwdata2_q <= hwdata1_q;
            hwrite1_q <= hwrite;
            hwrite2_q <= hwrite1_q;
        end
    end

    // Two-cycle ERROR: stall the master in ERR1, release it in ERR2. Bad accesses seen in ERR2 are dropped.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ERR_IDLE;
            hresp_q     <= HRESP_OKAY;
            err_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ERR_IDLE: begin
                    if (bad_access) begin
                        state_q     <= ERR_1;
                        hresp_q     <= HRESP_ERROR;
                        err_ready_q <= 1'b0;
                    end
                end
                ERR_1: begin
                    state_q     <= ERR_2;
                    err_ready_q <= 1'b1;
                end
                ERR_2: begin
                    state_q <= ERR_IDLE;
                    hresp_q <= HRESP_OKAY;
                end
                default: begin
                    state_q     <= ERR_IDLE;
                    hresp_q     <= HRESP_OKAY;
                    err_ready_q <= 1'b1;
                end
            endcase
        end
    end

    ahb_burst_tracker u_burst_tracker (
        .hclk      (hclk),
        .hreset    (hreset),
        .htrans    (htrans),
        .hburst    (hburst),
        .haddr     (haddr),
        .hreadyin  (hreadyin),
        .abort     (bad_access),
        .burst_err (burst_err)
    );

    assign haddr1      = haddr1_q;
    assign haddr2      = haddr2_q;
    assign hwdata1     = hwdata1_q;
    assign hwdata2     = hwdata2_q;
    assign hwrite_reg  = hwrite1_q;
    assign hwrite_reg1 = hwrite2_q;
    assign hrdata      = prdata;
    assign hresp       = hresp_q;
    assign hreadyout   = (state_q == ERR_IDLE) ? hr_readyout : err_ready_q;

endmodule

// File: doc/ahb_slave_interface.md
Name: ahb_slave_interface

Overview:
AHB-side front end of the AHB-to-APB bridge. It sits directly upstream of the APB controller.
- Qualifies AHB address phases and drives valid / temp_selx.
- Drives the two-deep address, data and hwrite pipelines the controller consumes.
- Generates the two-cycle AHB ERROR response and tracks fixed-length bursts.
- Returns read data from the APB side.

Parameters:
- NUM_SLAVES, 3, number of APB select lines (one-hot width of temp_selx).
- REGION_SIZE_LOG2, 26, log2 bytes per APB slave region.
- BASE_ADDR, 32'h8000_0000, base of slave 0 region; regions are contiguous.

Ports:
- hclk  in  1  bridge clock
- hreset  in  1  reset
- htrans  in  2  AHB transfer type
- hburst  in  3  AHB burst type
- hsize  in  3  AHB transfer size
- hwrite  in  1  AHB write/read
- hreadyin  in  1  AHB bus ready
- haddr  in  32  AHB address
- hwdata  in  32  AHB write data
- prdata  in  32  APB read data
- hr_readyout  in  1  ready from APB controller
- valid  out  1  qualified transfer to APB controller
- temp_selx  out  NUM_SLAVES  one-hot slave decode
- haddr1, haddr2  out  32  address pipeline stages 1 and 2
- hwdata1, hwdata2  out  32  write-data pipeline stages 1 and 2
- hwrite_reg, hwrite_reg1  out  1  hwrite pipeline stages 1 and 2
- hrdata  out  32  AHB read data
- hreadyout  out  1  AHB ready to master
- hresp  out  2  AHB response
- burst_err  out  1  sticky burst protocol violation

Behaviour:
- Reset: one clock (hclk); reset hreset is synchronous and active-high. On reset:
  - all pipeline registers, burst counter and burst_err go to 0;
  - error FSM goes to IDLE; hresp=OKAY(00).
- Pipeline: on each hclk edge with hreadyin=1:
  - haddr1<=haddr, haddr2<=haddr1;
  - hwdata1<=hwdata, hwdata2<=hwdata1;
  - hwrite_reg<=hwrite, hwrite_reg1<=hwrite_reg.
  - With hreadyin=0, all stages hold.
- Active phase: hreadyin=1 and htrans is NONSEQ(10) or SEQ(11).
- Decode (combinational from haddr): index = (haddr-BASE_ADDR)>>REGION_SIZE_LOG2.
  - temp_selx is one-hot of index if index<NUM_SLAVES, else 0.
  - Defaults: 8000_0000–83FF_FFFF→001, 8400_0000–87FF_FFFF→010, 8800_0000–8BFF_FFFF→100.
- Bad access: active phase and any of:
  - temp_selx==0;
  - hsize!=WORD(010);
  - haddr[1:0]!=0.
- valid (combinational) = active phase, no bad access, error FSM in IDLE.
- Error FSM:
  - IDLE→ERR1 on bad access.
  - ERR1: hreadyout=0, hresp=ERROR(01), valid=0; next ERR2.
  - ERR2: hreadyout=1, hresp=ERROR; valid=0; next IDLE.
  - A new bad access in ERR2 is ignored; the master must re-issue.
  - In IDLE: hreadyout=hr_readyout, hresp=OKAY.
- hrdata = prdata (combinational pass-through).
- Burst tracker (advances only when hreadyin=1):
  - NONSEQ with hburst INCR4/WRAP4 loads 3 remaining beats; INCR8/WRAP8 loads 7; INCR16/WRAP16 loads 15.
  - NONSEQ with SINGLE or INCR loads 0 and marks the burst unbounded.
  - Also on NONSEQ: capture last_addr=haddr.
  - SEQ: compare haddr with expected next address, then decrement the counter and update last_addr.
  - Expected address: last_addr+4 for INCR*. For WRAPn, the low k bits wrap with k=4/5/6 for WRAP4/8/16; upper bits are held.
  - BUSY(01): hold counter and last_addr. IDLE(00): clear counter.
  - burst_err sets (sticky until reset) on:
    - SEQ with counter==0 on a bounded burst;
    - SEQ with no preceding NONSEQ;
    - address mismatch;
    - NONSEQ/IDLE while counter!=0 (early termination).
  - burst_err does not gate valid.
- Simultaneous events:
  - A bad access mid-burst clears the counter and does not set burst_err.
  - hreset mid-burst or in ERR1/ERR2 returns everything to reset values at the next edge.

Decomposition:
- Shared package ahb_apb_pkg:
  - HTRANS codes IDLE/BUSY/NONSEQ/SEQ;
  - HBURST codes;
  - HRESP OKAY/ERROR;
  - HSIZE_WORD;
  - default BASE_ADDR and REGION_SIZE_LOG2;
  - error FSM state enum.
- One sub-module, ahb_burst_tracker: counter, expected-address compare and burst_err. Its inputs are htrans, hburst, haddr, hreadyin and abort.

Test Plan:
1. Reset with hreset=1 for 2 cycles, then drive haddr=8000_0000 NONSEQ write → during reset all outputs 0 and hresp=00; after release, first cycle shows valid=1, temp_selx=001; next edge haddr1=8000_0000.
2. Pipeline hold: writes to 8400_0000 then 8400_0004 with hwdata A5A5_0001/A5A5_0002; hreadyin=0 for 2 cycles between them → haddr1/haddr2 and hwdata1/hwdata2 frozen during the stall; haddr2=8400_0000 one edge after the second address is accepted.
3. Error response: NONSEQ to 9000_0000 → valid=0; ERR1 cycle hreadyout=0, hresp=01; ERR2 cycle hreadyout=1, hresp=01; then hresp=00. Repeat with 8000_0002, and with hsize=001 → same sequence.
4. INCR4 burst 8800_0000/04/08/0C → temp_selx=100, burst_err stays 0. WRAP4 burst starting 8000_0008 (08, 0C, 00, 04) → burst_err stays 0.
5. Burst violation: INCR4 from 8000_0000, second beat SEQ 8000_0008 → burst_err=1 next edge, and it stays 1 through later good bursts until hreset.
6. Read return: NONSEQ read to 8400_0010 with prdata=DEAD_BEEF → valid=1, temp_selx=010, hwrite_reg=0 next edge, hrdata=DEAD_BEEF same cycle as prdata.
